data_mem_master: RTL
====================

// Module: data_mem_master
// PURPOSE
//   Initiator-side load/store port driving the DataMemory block-RAM wrapper. Accepts one
//   load/store request at a time from the pipeline (valid/ready) and drives Addr/En_R/En_W/
//   Data_W from registers. Waits out the RAM read latency, then holds read data for the
//   pipeline (valid/ready). Sits between the MEM stage and DataMemory.
// PARAMETERS
//   ADDR_W  30  word-address width driven to memory (Mem_Addr = Req_Addr[ADDR_W+1:2])
//   RD_LAT  1   RAM read latency in clocks, from the edge sampling Mem_En_R to valid
//               Mem_Data_R; legal values 1..3
// PORTS
//   Clock         in   1       system clock, all logic on rising edge
//   Reset_N       in   1       asynchronous, active-low reset
//   Req_Valid     in   1       pipeline request valid
//   Req_Ready     out  1       unit can accept a request
//   Req_Write     in   1       1 = store, 0 = load
//   Req_Addr      in   32      byte address
//   Req_WData     in   32      store data
//   Rsp_Valid     out  1       load data valid
//   Rsp_Ready     in   1       pipeline accepts load data
//   Rsp_RData     out  32      load data
//   Mem_Addr      out  ADDR_W  to DataMemory Addr
//   Mem_En_R      out  1       to DataMemory En_R
//   Mem_En_W      out  1       to DataMemory En_W
//   Mem_Data_W    out  32      to DataMemory Data_W
//   Mem_Data_R    in   32      from DataMemory Data_R
//   Misalign_Err  out  1       one-cycle pulse on misaligned request (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0 except Req_Ready (1 after reset release); state IDLE; counter 0.
//   Accept = Req_Valid & Req_Ready; Req_Ready = (state == IDLE), registered.
//   All Mem_* outputs are registered; a request accepted at edge E0 drives Mem_* in E0..E1.
//   FSM:
//     IDLE:    store accept -> Mem_En_W = 1 for exactly one cycle; Mem_Addr/Mem_Data_W load;
//              stay IDLE, so back-to-back stores are allowed one per clock.
//              load accept -> Mem_En_R = 1 for one cycle; Mem_Addr loads; go RD_WAIT;
//              counter = 0.
//     RD_WAIT: counter increments each edge. At edge E1+RD_LAT (RD_LAT+1 edges after
//              accept), capture Mem_Data_R into Rsp_RData, set Rsp_Valid = 1, go RD_HOLD.
//     RD_HOLD: Rsp_Valid and Rsp_RData held stable while Rsp_Ready = 0. On Rsp_Ready = 1,
//              at the next edge Rsp_Valid = 0 and the FSM goes to IDLE (Req_Ready = 1).
//   Mem_En_R and Mem_En_W are never 1 in the same cycle.
//   Mem_Addr holds its last value when idle. Mem_Data_W changes only on store accept.
//   Req_Addr[31:ADDR_W+2] is ignored (no range check).
//   Req_Ready is low throughout RD_WAIT/RD_HOLD; a request presented then is not accepted
//   and must be held by the pipeline.
//   Reset_N low at any time: immediate return to reset values. An in-flight load is
//   discarded (no Rsp_Valid). A pending Mem_En_W pulse is cleared, so the store may be lost.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined: an accepted request with Req_Addr[1:0] != 0 issues no
//     Mem_En_R/Mem_En_W. Misalign_Err = 1 for the one cycle after accept. No response is
//     produced and the FSM stays in IDLE.
//   Not defined: Misalign_Err is tied to 0; Req_Addr[1:0] is ignored and all requests issue.
// TESTING
//   1 Store 0xDEADBEEF @0x0000_0010 -> next cycle Mem_En_W = 1 (one cycle),
//     Mem_Addr = 0x4, Mem_Data_W = 0xDEADBEEF; Req_Ready stays 1.
//   2 Load @0x10, RAM model RD_LAT = 1 returns 0xDEADBEEF -> Mem_En_R = 1 for one cycle;
//     Rsp_Valid rises 2 edges after accept, Rsp_RData = 0xDEADBEEF.
//   3 Load with Rsp_Ready = 0 for 5 cycles -> Rsp_Valid/Rsp_RData stable, Req_Ready = 0;
//     raise Rsp_Ready -> next cycle Rsp_Valid = 0, Req_Ready = 1.
//   4 Stores of 1,2,3,4 @0x0,0x4,0x8,0xC on 4 consecutive clocks, then load @0x8 ->
//     4 consecutive Mem_En_W pulses at Mem_Addr 0..3; load returns 3.
//   5 Reset_N low during RD_WAIT -> all outputs 0 at once; after release Req_Ready = 1;
//     Rsp_Valid never asserts for that load.
//   6 Load @0x13: with DMEM_ALIGN_CHECK_EN -> no Mem_En_R, Misalign_Err = 1 for one cycle,
//     Rsp_Valid stays 0; without it -> load issued with Mem_Addr = 0x4.

Source files
------------

// File: rtl/data_mem_master.sv
// Load/store initiator port between the MEM stage and the DataMemory block-RAM wrapper.
// Optional misaligned-request rejection is enabled by defining DMEM_ALIGN_CHECK_EN.

module data_mem_master_chk (
    input  logic        Clock,
    input  logic        Reset_N,
    input  logic        Mem_En_R,
    input  logic        Mem_En_W,
    input  logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    input  logic        Req_Ready,
    input  logic        Misalign_Err,
    input  logic [31:0] Rsp_RData
);

    a_en_exclusive: assert property (@(posedge Clock) disable iff (!Reset_N)
        !(Mem_En_R && Mem_En_W));

    a_en_r_pulse: assert property (@(posedge Clock) disable iff (!Reset_N)
        Mem_En_R |=> !Mem_En_R);

    a_rsp_hold: assert property (@(posedge Clock) disable iff (!Reset_N)
        (Rsp_Valid && !Rsp_Ready) |=> (Rsp_Valid && $stable(Rsp_RData)));

    a_rsp_drop: assert property (@(posedge Clock) disable iff (!Reset_N)
        (Rsp_Valid && Rsp_Ready) |=> !Rsp_Valid);

    a_ready_vs_rsp: assert property (@(posedge Clock) disable iff (!Reset_N)
        Rsp_Valid |-> !Req_Ready);

    a_err_quiet: assert property (@(posedge Clock) disable iff (!Reset_N)
        Misalign_Err |-> (!Mem_En_R && !Mem_En_W));

endmodule

module data_mem_master #(
    parameter int ADDR_W = 30,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [31:0]       Req_Addr,
    input  logic [31:0]       Req_WData,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [31:0]       Rsp_RData,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_En_R,
    output logic              Mem_En_W,
    output logic [31:0]       Mem_Data_W,
    input  logic [31:0]       Mem_Data_R,
    output logic              Misalign_Err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    state_t            state_r;
    logic [1:0]        cnt_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_en_r_r;
    logic              mem_en_w_r;
    logic [31:0]       mem_data_w_r;
    logic              misalign_err_r;

    logic              accept_s;
    logic              misalign_s;
    logic              issue_s;

`ifndef DMEM_ALIGN_CHECK_EN
    logic              unused_addr_lo_s;
    assign unused_addr_lo_s = ^Req_Addr[1:0];
`endif

    generate
        if (ADDR_W < 30) begin : g_addr_hi
            logic unused_addr_hi_s;
            assign unused_addr_hi_s = ^Req_Addr[31:ADDR_W+2];
        end
    endgenerate

    // Request handshake and alignment qualification
    always_comb begin
        accept_s = Req_Valid & req_ready_r;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_s = (Req_Addr[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
        issue_s = accept_s & ~misalign_s;
    end

    // Control FSM; every port-facing output is a register updated here
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 2'd0;
            req_ready_r    <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_en_r_r     <= 1'b0;
            mem_en_w_r     <= 1'b0;
            mem_data_w_r   <= 32'h0000_0000;
            misalign_err_r <= 1'b0;
        end else begin
            mem_en_r_r     <= 1'b0;
            mem_en_w_r     <= 1'b0;
            misalign_err_r <= accept_s & misalign_s;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        mem_addr_r <= Req_Addr[ADDR_W+1:2];
                        if (Req_Write) begin
                            // Stores complete in one beat, so the port stays ready
                            mem_en_w_r   <= 1'b1;
                            mem_data_w_r <= Req_WData;
                            req_ready_r  <= 1'b1;
                        end else begin
                            mem_en_r_r  <= 1'b1;
                            cnt_r       <= 2'd0;
                            state_r     <= ST_RD_WAIT;
                            req_ready_r <= 1'b0;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    req_ready_r <= 1'b0;
                    // cnt_r == RD_LAT marks edge E1+RD_LAT, when Mem_Data_R is valid
                    if (cnt_r == RD_LAT_C) begin
                        rsp_rdata_r <= Mem_Data_R;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 2'd0;
                        state_r     <= ST_RD_HOLD;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_RD_HOLD: begin
                    if (Rsp_Ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        req_ready_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    cnt_r       <= 2'd0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign Req_Ready    = req_ready_r;
    assign Rsp_Valid    = rsp_valid_r;
    assign Rsp_RData    = rsp_rdata_r;
    assign Mem_Addr     = mem_addr_r;
    assign Mem_En_R     = mem_en_r_r;
    assign Mem_En_W     = mem_en_w_r;
    assign Mem_Data_W   = mem_data_w_r;
    assign Misalign_Err = misalign_err_r;

    data_mem_master_chk u_chk (
        .Clock        (Clock),
        .Reset_N      (Reset_N),
        .Mem_En_R     (Mem_En_R),
        .Mem_En_W     (Mem_En_W),
        .Rsp_Valid    (Rsp_Valid),
        .Rsp_Ready    (Rsp_Ready),
        .Req_Ready    (Req_Ready),
        .Misalign_Err (Misalign_Err),
        .Rsp_RData    (Rsp_RData)
    );

endmodule
